// File: rtl/npc_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, size helper.
package npc_lsu_pkg;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction
endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane steering: store mask/data placement and load extraction with extension.
module npc_lsu_align
    import npc_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      i_size,
    input  logic [2:0]      i_off,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [7:0]      o_wmask,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ldata
);
    logic [7:0]      w_lanes;
    logic [XLEN-1:0] w_shr;
    logic            w_sx;

    always_comb begin
        case (i_size)
            SZ_B:    w_lanes = 8'h01;
            SZ_H:    w_lanes = 8'h03;
            SZ_W:    w_lanes = 8'h0F;
            default: w_lanes = 8'hFF;
        endcase
    end

    assign o_wmask = w_lanes << i_off;
    assign o_wdata = i_wdata << {i_off, 3'b000};
    assign w_shr   = i_rdata >> {i_off, 3'b000};
    assign w_sx    = ~i_unsigned;

    always_comb begin
        case (i_size)
            SZ_B:    o_ldata = {{(XLEN-8){w_sx & w_shr[7]}},   w_shr[7:0]};
            SZ_H:    o_ldata = {{(XLEN-16){w_sx & w_shr[15]}}, w_shr[15:0]};
            SZ_W:    o_ldata = {{(XLEN-32){w_sx & w_shr[31]}}, w_shr[31:0]};
            default: o_ldata = w_shr;
        endcase
    end
endmodule

// File: rtl/npc_lsu.sv
// Load/store unit: one request at a time, one aligned 8-byte memory access per request.
module npc_lsu
    import npc_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic [RD_W-1:0] out_rd,
    output logic            out_misalign,
    output logic [XLEN-1:0] mem_raddr,
    output logic            mem_read,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    output logic            mem_write,
    input  logic [XLEN-1:0] mem_rdata
);
    state_t          r_state, w_next;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
    logic [1:0]      r_size;
    logic            r_store, r_uns, r_misalign;
    logic [RD_W-1:0] r_rd;
    logic [3:0]      w_sb;
    logic            w_mis;
    logic [7:0]      w_wmask;
    logic [XLEN-1:0] w_wdata, w_ldata, w_aligned;

    assign w_sb      = size_bytes(in_size);
    assign w_mis     = (in_addr[2:0] & 3'(w_sb - 4'd1)) != 3'd0;
    assign w_aligned = {r_addr[XLEN-1:3], 3'b000};

    npc_lsu_align #(.XLEN(XLEN)) u_align (
        .i_size     (r_size),
        .i_off      (r_addr[2:0]),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .i_rdata    (mem_rdata),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid) w_next = w_mis ? ST_DONE : ST_ACCESS;
            ST_ACCESS: w_next = ST_DONE;
            ST_DONE:   if (out_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Request capture, load result capture at the end of ACCESS, misalign flag clear on hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_size     <= SZ_B;
            r_store    <= 1'b0;
            r_uns      <= 1'b0;
            r_misalign <= 1'b0;
            r_rd       <= '0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_addr     <= in_addr;
                r_wdata    <= in_wdata;
                r_size     <= in_size;
                r_store    <= in_store;
                r_uns      <= in_unsigned;
                r_rd       <= in_rd;
                r_misalign <= w_mis;
                r_rdata    <= '0;
            end
            if (r_state == ST_ACCESS) r_rdata <= r_store ? '0 : w_ldata;
            if (r_state == ST_DONE && out_ready) r_misalign <= 1'b0;
        end
    end

    always_comb begin
        in_ready     = (r_state == ST_IDLE);
        out_valid    = (r_state == ST_DONE);
        out_rdata    = r_rdata;
        out_rd       = r_rd;
        out_misalign = r_misalign;
        mem_read     = (r_state == ST_ACCESS) && !r_store;
        mem_write    = (r_state == ST_ACCESS) && r_store;
        mem_raddr    = mem_read  ? w_aligned : '0;
        mem_waddr    = mem_write ? w_aligned : '0;
        mem_wdata    = mem_write ? w_wdata   : '0;
        mem_wmask    = mem_write ? w_wmask   : 8'h00;
    end
endmodule

// File: tb/tb_npc_lsu.sv
// Randomized + directed bench for npc_lsu against a byte-array memory reference model.
module tb_npc_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_store, in_unsigned;
    logic [1:0]  in_size;
    logic [63:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready, out_misalign;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_wmask;

    logic [7:0]  mem_b [0:127];
    int          n_chk = 0, n_pass = 0, cyc = 0;

    npc_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
        .out_misalign(out_misalign), .mem_raddr(mem_raddr), .mem_read(mem_read),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responds combinationally from the reference byte array.
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem_b[{mem_raddr[6:3], 3'(i)}];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] a, input int n, input bit uns);
        logic [63:0] v;
        logic [6:0]  idx;
        v = '0;
        for (int i = 0; i < n; i++) begin
            idx = 7'(a + 64'(i));
            v = v | (64'(mem_b[idx]) << (8*i));
        end
        if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input int n, input logic [63:0] wd);
        logic [6:0] idx;
        for (int i = 0; i < n; i++) begin
            idx = 7'(a + 64'(i));
            mem_b[idx] = wd[8*i +: 8];
        end
    endtask

    // One full request with bp cycles of writeback backpressure; returns observed out_rdata.
    task automatic do_req(input bit st, input logic [1:0] sz, input bit uns, input logic [63:0] a,
                          input logic [63:0] wd, input logic [4:0] rd, input int bp,
                          output logic [63:0] got);
        int          n, off;
        bit          mis;
        logic [63:0] exp;
        n   = 1 << sz;
        off = int'(a[2:0]);
        mis = (a % 64'(n)) != 0;
        exp = (!st && !mis) ? ref_load(a, n, uns) : 64'd0;
        @(negedge clk);
        in_valid = 1; in_store = st; in_size = sz; in_unsigned = uns;
        in_addr = a; in_wdata = wd; in_rd = rd; out_ready = (bp == 0);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 0;
        if (!mis) begin
            chk("access_out_valid", 64'(out_valid), 64'd0);
            chk("access_in_ready", 64'(in_ready), 64'd0);
            chk("mem_read", 64'(mem_read), 64'(!st));
            chk("mem_write", 64'(mem_write), 64'(st));
            if (st) begin
                chk("mem_waddr", mem_waddr, a & ~64'd7);
                chk("mem_wmask", 64'(mem_wmask), 64'(8'(((16'd1 << n) - 16'd1) << off)));
                chk("mem_wdata", mem_wdata, wd << (8*off));
                chk("mem_raddr_st", mem_raddr, 64'd0);
                ref_store(a, n, wd);
            end else begin
                chk("mem_raddr", mem_raddr, a & ~64'd7);
                chk("mem_waddr_ld", mem_waddr, 64'd0);
            end
            @(negedge clk);
        end
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_rdata", out_rdata, exp);
        chk("out_rd", 64'(out_rd), 64'(rd));
        chk("out_misalign", 64'(out_misalign), 64'(mis));
        chk("done_strobes", 64'({mem_read, mem_write}), 64'd0);
        got = out_rdata;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_rdata", out_rdata, exp);
            chk("bp_out_rd", 64'(out_rd), 64'(rd));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            if (k == bp - 1) out_ready = 1;
        end
        @(negedge clk);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_misalign", 64'(out_misalign), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, e0, e1, e2, a;
        logic [63:0] b2b_addr [3];
        logic [1:0]  b2b_sz [3];
        int          acc [3];
        int          t;

        for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) mem_b[i] = 8'(64'h1122334455667788 >> (8*i));
        rst = 1; in_valid = 0; in_store = 0; in_size = 0; in_unsigned = 0;
        in_addr = 0; in_wdata = 0; in_rd = 0; out_ready = 1;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_rdata", out_rdata, 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_misalign", 64'(out_misalign), 64'd0);
        chk("rst_mem", 64'({mem_read, mem_write, mem_wmask}), 64'd0);
        chk("rst_mem_addr", mem_raddr | mem_waddr | mem_wdata, 64'd0);
        @(negedge clk); @(negedge clk); rst = 0;

        do_req(0, 2'd0, 0, 64'h80000007, 0, 5'd1, 0, got); chk("lb_off7", got, 64'h11);
        do_req(0, 2'd0, 0, 64'h80000001, 0, 5'd2, 0, got); chk("lb_off1", got, 64'h77);
        do_req(0, 2'd0, 0, 64'h80000000, 0, 5'd3, 0, got); chk("lb_off0", got, 64'hFFFFFFFFFFFFFF88);
        do_req(0, 2'd0, 1, 64'h80000000, 0, 5'd4, 0, got); chk("lbu_off0", got, 64'h88);
        do_req(1, 2'd1, 0, 64'h80000006, 64'hABCD, 5'd5, 0, got); chk("sh_out_rdata", got, 64'd0);
        do_req(0, 2'd3, 0, 64'h80000000, 0, 5'd6, 5, got); chk("ld_after_sh", got, 64'hABCD334455667788);
        do_req(0, 2'd2, 0, 64'h80000002, 0, 5'd7, 0, got); chk("lw_misalign", got, 64'd0);

        // Back-to-back loads with in_valid held high: accepts must be 3 cycles apart.
        b2b_addr[0] = 64'h80000000; b2b_sz[0] = 2'd3;
        b2b_addr[1] = 64'h80000008; b2b_sz[1] = 2'd2;
        b2b_addr[2] = 64'h80000004; b2b_sz[2] = 2'd1;
        @(negedge clk);
        out_ready = 1; in_valid = 1; in_store = 0; in_unsigned = 0;
        for (int k = 0; k < 3; k++) begin
            in_addr = b2b_addr[k]; in_size = b2b_sz[k]; in_rd = 5'(10 + k);
            e0 = ref_load(b2b_addr[k], 1 << b2b_sz[k], 0);
            t = 0;
            while (!in_ready && t < 10) begin @(negedge clk); t++; end
            chk("b2b_accept_timeout", 64'(in_ready), 64'd1);
            acc[k] = cyc;
            @(negedge clk);
            if (k == 2) in_valid = 0;
            t = 0;
            while (!out_valid && t < 10) begin @(negedge clk); t++; end
            chk("b2b_out_valid", 64'(out_valid), 64'd1);
            chk("b2b_rdata", out_rdata, e0);
            chk("b2b_rd", 64'(out_rd), 64'(10 + k));
            @(negedge clk);
        end
        chk("b2b_gap01", 64'(acc[1] - acc[0]), 64'd3);
        chk("b2b_gap12", 64'(acc[2] - acc[1]), 64'd3);

        // Reset during ACCESS of a store drops it.
        @(negedge clk);
        in_valid = 1; in_store = 1; in_size = 2'd3; in_addr = 64'h80000010;
        in_wdata = 64'hDEADBEEF; in_rd = 5'd20;
        @(negedge clk);
        in_valid = 0;
        chk("rst_mid_write_hi", 64'(mem_write), 64'd1);
        rst = 1; #1;
        chk("rst_mid_write_lo", 64'(mem_write), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", 64'(out_valid), 64'd0);
        end

        for (int r = 0; r < 60; r++) begin
            a = 64'h80000000 + 64'($urandom_range(0, 127));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom},
                   5'($urandom), int'($urandom_range(0, 2)), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
